// File: rtl/reset_sequencer_if.sv
// Bundle of sequencer control/status signals between the reset sequencer and its clients.
interface reset_sequencer_if #(
  parameter int unsigned DOMAINS = 4
);
  localparam int unsigned StageW = $clog2(DOMAINS + 1);

  logic                soft_reset;
  logic [DOMAINS-1:0]  ready;
  logic [DOMAINS-1:0]  rst_out;
  logic                busy;
  logic                done;
  logic [StageW-1:0]   stage;
  logic                fault;

  // Sequencer side
  modport master (
    input  soft_reset,
    input  ready,
    output rst_out,
    output busy,
    output done,
    output stage,
    output fault
  );

  // Client side (domains and software)
  modport slave (
    output soft_reset,
    output ready,
    input  rst_out,
    input  busy,
    input  done,
    input  stage,
    input  fault
  );
endinterface

// File: rtl/reset_sequencer.sv
// Ordered reset-release controller: releases domains one at a time, waiting for each
// domain's ready before moving on; restarts on timeout, ready loss or software request.
module reset_sequencer #(
  parameter int unsigned DOMAINS        = 4,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic              i_clk,
  input  logic              i_areset,
  reset_sequencer_if.master io_seq
);

  localparam int unsigned SW       = $clog2(DOMAINS + 1);
  localparam int unsigned HW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned ToMaxInt = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  localparam logic [HW-1:0] HoldMax   = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] ToMax     = TW'(ToMaxInt);
  localparam logic [SW-1:0] StageLast = SW'(DOMAINS - 1);
  localparam logic [SW-1:0] StageDone = SW'(DOMAINS);

  typedef enum logic [1:0] {StHold, StWait, StDone, StRestart} state_e;

  logic [SYNC_STAGES-1:0]              r_rst_sync;
  logic                                w_rst_n;
  logic [SYNC_STAGES-1:0][DOMAINS-1:0] r_rdy_sync;
  logic [DOMAINS-1:0]                  w_rdy_s;

  state_e             r_state, w_state_d;
  logic [SW-1:0]      r_stage, w_stage_d;
  logic [HW-1:0]      r_hold_cnt, w_hold_cnt_d;
  logic [TW-1:0]      r_to_cnt, w_to_cnt_d;
  logic [DOMAINS-1:0] r_rst_out, w_rst_out_d;
  logic               r_busy, w_busy_d;
  logic               r_done, w_done_d;
  logic               r_fault, w_fault_d;
  logic               w_rdy_cur;
  logic               w_timeout;

  // Reset synchronizer: asynchronous assertion, clocked deassertion
  always_ff @(posedge i_clk or negedge i_areset) begin
    if (!i_areset) r_rst_sync <= '0;
    else           r_rst_sync <= {r_rst_sync[SYNC_STAGES-2:0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[SYNC_STAGES-1];

  // Ready synchronizer chain, one column per domain
  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_rdy_sync <= '0;
    else          r_rdy_sync <= {r_rdy_sync[SYNC_STAGES-2:0], io_seq.ready};
  end

  assign w_rdy_s = r_rdy_sync[SYNC_STAGES-1];

  // Select the synchronized ready of the domain being sequenced (none once stage == DOMAINS)
  always_comb begin
    w_rdy_cur = 1'b0;
    for (int i = 0; i < int'(DOMAINS); i++) begin
      if (r_stage == SW'(i)) w_rdy_cur = w_rdy_s[i];
    end
  end

  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_state == StWait) && !w_rdy_cur &&
                     (r_to_cnt == ToMax);

  // State register
  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= StHold;
    else          r_state <= w_state_d;
  end

  // Next-state logic; soft_reset overrides every other transition
  always_comb begin
    w_state_d = r_state;
    if (io_seq.soft_reset) begin
      w_state_d = StRestart;
    end else begin
      case (r_state)
        StHold:    if (r_hold_cnt == HoldMax) w_state_d = StWait;
        StWait: begin
          if (w_rdy_cur)      w_state_d = (r_stage == StageLast) ? StDone : StHold;
          else if (w_timeout) w_state_d = StRestart;
        end
        StDone:    if (!(&w_rdy_s)) w_state_d = StRestart;
        StRestart: w_state_d = StHold;
        default:   w_state_d = StRestart;
      endcase
    end
  end

  // Output/datapath next values, derived from the transition being taken
  always_comb begin
    w_stage_d    = r_stage;
    w_hold_cnt_d = '0;
    w_to_cnt_d   = '0;
    w_rst_out_d  = r_rst_out;
    w_fault_d    = r_fault | (w_timeout & ~io_seq.soft_reset);
    w_busy_d     = (w_state_d != StDone);
    w_done_d     = (w_state_d == StDone);
    case (w_state_d)
      StRestart: begin
        w_stage_d   = '0;
        w_rst_out_d = '1;
      end
      StHold: begin
        if (r_state == StHold)      w_hold_cnt_d = r_hold_cnt + 1'b1;
        else if (r_state == StWait) w_stage_d    = r_stage + 1'b1;
      end
      StWait: begin
        if (r_state == StHold) begin
          for (int i = 0; i < int'(DOMAINS); i++) begin
            if (r_stage == SW'(i)) w_rst_out_d[i] = 1'b0;
          end
        end else if (TIMEOUT_CYCLES != 0) begin
          w_to_cnt_d = r_to_cnt + 1'b1;
        end
      end
      StDone: begin
        w_stage_d   = StageDone;
        w_rst_out_d = '0;
      end
      default: ;
    endcase
  end

  // Registered outputs and counters
  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_stage    <= '0;
      r_hold_cnt <= '0;
      r_to_cnt   <= '0;
      r_rst_out  <= '1;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_stage    <= w_stage_d;
      r_hold_cnt <= w_hold_cnt_d;
      r_to_cnt   <= w_to_cnt_d;
      r_rst_out  <= w_rst_out_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
      r_fault    <= w_fault_d;
    end
  end

  assign io_seq.rst_out = r_rst_out;
  assign io_seq.busy    = r_busy;
  assign io_seq.done    = r_done;
  assign io_seq.stage   = r_stage;
  assign io_seq.fault   = r_fault;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer (3 domains, hold 4, timeout 16, sync 2) plus a
// timeout-disabled instance.
module tb_reset_sequencer;

  localparam int D = 3;
  localparam int H = 4;
  localparam int T = 16;
  localparam int S = 2;

  typedef int arr_t [D];

  logic clk = 1'b0;
  logic clk_en = 1'b1;
  logic areset;
  logic areset_z;
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;

  reset_sequencer_if #(.DOMAINS(D)) seq_if ();
  reset_sequencer_if #(.DOMAINS(D)) seq_z ();

  reset_sequencer #(
    .DOMAINS(D), .HOLD_CYCLES(H), .TIMEOUT_CYCLES(T), .SYNC_STAGES(S)
  ) u_dut (
    .i_clk    (clk),
    .i_areset (areset),
    .io_seq   (seq_if)
  );

  reset_sequencer #(
    .DOMAINS(D), .HOLD_CYCLES(H), .TIMEOUT_CYCLES(0), .SYNC_STAGES(S)
  ) u_dut_z (
    .i_clk    (clk),
    .i_areset (areset_z),
    .io_seq   (seq_z)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference: walk the release order with per-domain ready-visible cycles.
  // Each stage: HOLD starts at t, release at t+H, advance the cycle after ready is seen,
  // or restart from stage 0 if ready is not seen within T cycles of release.
  function automatic void model_seq(input int t0, input arr_t rise, input int floor_c,
                                    output arr_t rel, output int done_c, output int fault_c);
    int t, j, r, seen, n;
    arr_t rdy_at;
    for (int i = 0; i < D; i++) begin
      rdy_at[i] = rise[i] + S;
      if (rdy_at[i] < floor_c) rdy_at[i] = floor_c;
      rel[i] = -1;
    end
    t = t0; j = 0; n = 0; fault_c = -1;
    while (j < D && n < 100) begin
      r      = t + H;
      rel[j] = r;
      seen   = (rdy_at[j] > r) ? rdy_at[j] : r;
      if (seen > r + T - 1) begin
        if (fault_c < 0) fault_c = r + T;
        t = r + T + 1;
        j = 0;
        n++;
      end else begin
        t = seen + 1;
        j++;
      end
    end
    done_c = t;
  endfunction

  // Drive ready pins (pin j high from cycle rise[j]) and record what the DUT does
  task automatic run_observe(input arr_t rise, input int limit, output arr_t rel,
                             output int done_c, output int fault_c, output int overlap);
    logic [D-1:0] prev;
    for (int j = 0; j < D; j++) rel[j] = -1;
    done_c = -1; fault_c = -1; overlap = 0;
    prev = seq_if.rst_out;
    for (int n = 0; n < limit; n++) begin
      for (int j = 0; j < D; j++) seq_if.ready[j] = (cyc >= rise[j]);
      tick();
      if (seq_if.busy === seq_if.done) overlap++;
      for (int j = 0; j < D; j++)
        if (prev[j] === 1'b1 && seq_if.rst_out[j] === 1'b0) rel[j] = cyc;
      prev = seq_if.rst_out;
      if (seq_if.fault === 1'b1 && fault_c < 0) fault_c = cyc;
      if (seq_if.done === 1'b1) begin
        done_c = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    areset = 1'b0; areset_z = 1'b0;
    seq_if.soft_reset = 1'b0; seq_z.soft_reset = 1'b0;
    seq_if.ready = 3'b111; seq_z.ready = 3'b110;
    tick(); tick(); tick();
    n_run++; if (seq_if.rst_out !== 3'b111) begin n_fail++;
      $display("FAIL reset_rst_out: got %b expected 111", seq_if.rst_out); end
    n_run++; if (seq_if.busy !== 1'b1) begin n_fail++;
      $display("FAIL reset_busy: got %b expected 1", seq_if.busy); end
    n_run++; if (seq_if.done !== 1'b0) begin n_fail++;
      $display("FAIL reset_done: got %b expected 0", seq_if.done); end
    n_run++; if (seq_if.stage !== 2'd0) begin n_fail++;
      $display("FAIL reset_stage: got %0d expected 0", seq_if.stage); end
    n_run++; if (seq_if.fault !== 1'b0) begin n_fail++;
      $display("FAIL reset_fault: got %b expected 0", seq_if.fault); end
  endtask

  task automatic test_sequence();
    int k, t0, dc, fc, ov;
    arr_t rise, rel;
    k = cyc;
    areset = 1'b1;
    t0 = k + S;
    rise = '{0, 0, 0};
    run_observe(rise, 60, rel, dc, fc, ov);
    for (int j = 0; j < D; j++) begin
      n_run++; if (rel[j] !== t0 + j * (H + 1) + H) begin n_fail++;
        $display("FAIL seq_release%0d: got %0d expected %0d", j, rel[j] - t0,
                 j * (H + 1) + H); end
    end
    n_run++; if (dc !== t0 + D * (H + 1)) begin n_fail++;
      $display("FAIL seq_done_cycle: got %0d expected %0d", dc - t0, D * (H + 1)); end
    n_run++; if (fc !== -1) begin n_fail++;
      $display("FAIL seq_fault: got cycle %0d expected none", fc); end
    n_run++; if (seq_if.stage !== 2'd3) begin n_fail++;
      $display("FAIL seq_stage_done: got %0d expected 3", seq_if.stage); end
    n_run++; if (ov !== 0) begin n_fail++;
      $display("FAIL seq_busy_done_excl: got %0d bad cycles expected 0", ov); end
  endtask

  task automatic test_done_drop();
    int k, dc, fc, ov, edc, efc;
    arr_t rise, rel, erel;
    k = cyc;
    seq_if.ready[0] = 1'b0;
    tick(); tick();
    n_run++; if (seq_if.done !== 1'b1) begin n_fail++;
      $display("FAIL drop_still_done: got %b expected 1", seq_if.done); end
    tick();
    n_run++; if ({seq_if.rst_out, seq_if.busy, seq_if.done, seq_if.stage} !== 7'b1111000)
    begin n_fail++;
      $display("FAIL drop_restart: got rst=%b busy=%b done=%b stage=%0d expected 111/1/0/0",
               seq_if.rst_out, seq_if.busy, seq_if.done, seq_if.stage); end
    rise = '{k + 3, 0, 0};
    run_observe(rise, 60, rel, dc, fc, ov);
    model_seq(k + 4, rise, 0, erel, edc, efc);
    n_run++; if (dc !== edc) begin n_fail++;
      $display("FAIL drop_done_cycle: got %0d expected %0d", dc - k, edc - k); end
    for (int j = 0; j < D; j++) begin
      n_run++; if (rel[j] !== erel[j]) begin n_fail++;
        $display("FAIL drop_release%0d: got %0d expected %0d", j, rel[j] - k, erel[j] - k); end
    end
    n_run++; if (ov !== 0) begin n_fail++;
      $display("FAIL drop_busy_done_excl: got %0d expected 0", ov); end
  endtask

  task automatic test_soft_reset();
    int k, dc, fc, ov, edc, efc;
    bit found;
    arr_t rise, rel, erel;
    found = 1'b0;
    seq_if.ready[2] = 1'b0;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (seq_if.stage === 2'd2 && seq_if.rst_out === 3'b000) begin
        found = 1'b1;
        break;
      end
    end
    n_run++; if (!found) begin n_fail++;
      $display("FAIL soft_reach_wait2: got stage %0d rst %b expected 2 000",
               seq_if.stage, seq_if.rst_out); end
    tick(); tick();
    k = cyc;
    seq_if.soft_reset = 1'b1;
    seq_if.ready[2] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_run++; if ({seq_if.rst_out, seq_if.busy, seq_if.done} !== 5'b11110) begin n_fail++;
        $display("FAIL soft_hold_c%0d: got rst=%b busy=%b done=%b expected 111/1/0", i,
                 seq_if.rst_out, seq_if.busy, seq_if.done); end
    end
    seq_if.soft_reset = 1'b0;
    tick();
    n_run++; if (seq_if.stage !== 2'd0 || seq_if.rst_out !== 3'b111) begin n_fail++;
      $display("FAIL soft_hold_entry: got stage %0d rst %b expected 0 111",
               seq_if.stage, seq_if.rst_out); end
    rise = '{0, 0, 0};
    run_observe(rise, 60, rel, dc, fc, ov);
    model_seq(k + 11, rise, 0, erel, edc, efc);
    n_run++; if (rel[0] !== erel[0]) begin n_fail++;
      $display("FAIL soft_release0: got %0d expected %0d", rel[0] - k, erel[0] - k); end
    n_run++; if (dc !== edc) begin n_fail++;
      $display("FAIL soft_done_cycle: got %0d expected %0d", dc - k, edc - k); end
    n_run++; if (fc !== -1) begin n_fail++;
      $display("FAIL soft_fault: got cycle %0d expected none", fc - k); end
  endtask

  task automatic test_timeout();
    int k, dc, fc, ov, edc, efc;
    arr_t rise, rel, erel;
    k = cyc;
    seq_if.ready[1] = 1'b0;
    tick(); tick(); tick();
    n_run++; if (seq_if.done !== 1'b0 || seq_if.rst_out !== 3'b111) begin n_fail++;
      $display("FAIL tmo_restart: got done %b rst %b expected 0 111",
               seq_if.done, seq_if.rst_out); end
    rise = '{0, k + 30, 0};
    run_observe(rise, 200, rel, dc, fc, ov);
    model_seq(k + 4, rise, 0, erel, edc, efc);
    n_run++; if (fc !== efc) begin n_fail++;
      $display("FAIL tmo_fault_cycle: got %0d expected %0d", fc - k, efc - k); end
    n_run++; if (dc !== edc) begin n_fail++;
      $display("FAIL tmo_done_cycle: got %0d expected %0d", dc - k, edc - k); end
    for (int j = 0; j < D; j++) begin
      n_run++; if (rel[j] !== erel[j]) begin n_fail++;
        $display("FAIL tmo_release%0d: got %0d expected %0d", j, rel[j] - k, erel[j] - k); end
    end
    n_run++; if (seq_if.fault !== 1'b1) begin n_fail++;
      $display("FAIL tmo_fault_sticky: got %b expected 1", seq_if.fault); end
  endtask

  task automatic test_areset();
    int k, dc, fc, ov, edc, efc;
    arr_t rise, rel, erel;
    seq_if.soft_reset = 1'b1;
    tick();
    seq_if.soft_reset = 1'b0;
    k = cyc;
    for (int i = 0; i < 8; i++) tick();
    n_run++; if (seq_if.stage !== 2'd1 || seq_if.rst_out !== 3'b110) begin n_fail++;
      $display("FAIL ares_mid_hold: got stage %0d rst %b expected 1 110",
               seq_if.stage, seq_if.rst_out); end
    clk_en = 1'b0;
    #3;
    areset = 1'b0;
    #1;
    n_run++; if (seq_if.rst_out !== 3'b111) begin n_fail++;
      $display("FAIL ares_rst_async: got %b expected 111", seq_if.rst_out); end
    n_run++; if (seq_if.stage !== 2'd0) begin n_fail++;
      $display("FAIL ares_stage: got %0d expected 0", seq_if.stage); end
    n_run++; if (seq_if.fault !== 1'b0) begin n_fail++;
      $display("FAIL ares_fault_clear: got %b expected 0", seq_if.fault); end
    n_run++; if (seq_if.busy !== 1'b1 || seq_if.done !== 1'b0) begin n_fail++;
      $display("FAIL ares_busy_done: got %b%b expected 10", seq_if.busy, seq_if.done); end
    #5;
    areset = 1'b1;
    #2;
    clk_en = 1'b1;
    k = cyc;
    rise = '{0, 0, 0};
    run_observe(rise, 60, rel, dc, fc, ov);
    model_seq(k + S, rise, k + 2 * S, erel, edc, efc);
    n_run++; if (dc !== edc) begin n_fail++;
      $display("FAIL ares_done_cycle: got %0d expected %0d", dc - k, edc - k); end
    n_run++; if (fc !== -1) begin n_fail++;
      $display("FAIL ares_fault_after: got cycle %0d expected none", fc - k); end
  endtask

  task automatic test_random();
    int k, dc, fc, ov, edc, efc;
    arr_t rise, rel, erel;
    for (int run = 0; run < 8; run++) begin
      seq_if.ready = '0;
      areset = 1'b0;
      tick(); tick();
      n_run++; if (seq_if.rst_out !== 3'b111 || seq_if.fault !== 1'b0) begin n_fail++;
        $display("FAIL rnd%0d_reset: got rst %b fault %b expected 111 0", run,
                 seq_if.rst_out, seq_if.fault); end
      k = cyc;
      areset = 1'b1;
      for (int j = 0; j < D; j++) rise[j] = k + int'($urandom_range(0, 40));
      run_observe(rise, 600, rel, dc, fc, ov);
      model_seq(k + S, rise, k + 2 * S, erel, edc, efc);
      n_run++; if (dc !== edc) begin n_fail++;
        $display("FAIL rnd%0d_done_cycle: got %0d expected %0d", run, dc - k, edc - k); end
      n_run++; if (fc !== efc) begin n_fail++;
        $display("FAIL rnd%0d_fault_cycle: got %0d expected %0d", run, fc, efc); end
      for (int j = 0; j < D; j++) begin
        n_run++; if (rel[j] !== erel[j]) begin n_fail++;
          $display("FAIL rnd%0d_release%0d: got %0d expected %0d", run, j, rel[j] - k,
                   erel[j] - k); end
      end
      n_run++; if (ov !== 0) begin n_fail++;
        $display("FAIL rnd%0d_busy_done_excl: got %0d expected 0", run, ov); end
    end
  endtask

  task automatic test_zero_timeout();
    int m, dc;
    areset_z = 1'b1;
    for (int i = 0; i < 5000; i++) tick();
    n_run++; if (seq_z.fault !== 1'b0) begin n_fail++;
      $display("FAIL zto_fault: got %b expected 0", seq_z.fault); end
    n_run++; if (seq_z.stage !== 2'd0) begin n_fail++;
      $display("FAIL zto_stage: got %0d expected 0", seq_z.stage); end
    n_run++; if (seq_z.rst_out !== 3'b110) begin n_fail++;
      $display("FAIL zto_rst_out: got %b expected 110", seq_z.rst_out); end
    n_run++; if (seq_z.busy !== 1'b1 || seq_z.done !== 1'b0) begin n_fail++;
      $display("FAIL zto_busy_done: got %b%b expected 10", seq_z.busy, seq_z.done); end
    m = cyc;
    seq_z.ready = 3'b111;
    dc = -1;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (seq_z.done === 1'b1) begin
        dc = cyc;
        break;
      end
    end
    // ready visible after S cycles, then one cycle to advance, then two full stages
    n_run++; if (dc !== m + S + 1 + (D - 1) * (H + 1)) begin n_fail++;
      $display("FAIL zto_done_cycle: got %0d expected %0d", dc - m,
               S + 1 + (D - 1) * (H + 1)); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_done_drop();
    test_soft_reset();
    test_timeout();
    test_areset();
    test_random();
    test_zero_timeout();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
